// File: rtl/adc_spi_pkg.sv
// Shared constants and types for the ADC SPI responder: frame layout,
// address field position, FSM state encoding and the sample bus type.
package adc_spi_pkg;

    localparam int NUM_CH_DEF      = 8;
    localparam int DATA_W_DEF      = 12;
    localparam int FRAME_BITS      = 16;
    localparam int LEAD_ZEROS      = 4;
    localparam int ADDR_FIRST_EDGE = 2;
    localparam int ADDR_W          = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } resp_state_t;

    typedef logic [NUM_CH_DEF-1:0][DATA_W_DEF-1:0] sample_bus_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for an asynchronous pin followed by a one-flop
// edge detector producing single-cycle rise/fall strobes.
module spi_edge_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              w_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= w_level;
        end
    end

    assign w_level = r_sync[STAGES-1];
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/adc_spi_responder.sv
// Device-side emulation of the 8-channel 12-bit serial ADC: decodes the
// channel address from ADC_DIN and shifts a snapshotted sample out on ADC_DOUT.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             ADC_CS_N,
    input  logic                             ADC_SCLK,
    input  logic                             ADC_DIN,
    output logic                             ADC_DOUT,
    output logic                             dout_oe,
    input  logic [NUM_CH-1:0][DATA_W-1:0]    sample_in,
    output logic [$clog2(NUM_CH)-1:0]        cur_addr,
    output logic                             frame_done,
    output logic [15:0]                      frame_count,
    output resp_state_t                      dbg_state
);

    localparam int AW = $clog2(NUM_CH);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_din;
    logic [SYNC_STAGES-1:0] r_din_sync;

    resp_state_t r_state, w_state_next;

    logic [BW-1:0]     r_bit_cnt,     w_bit_cnt_n;
    logic [DATA_W-1:0] r_shift,       w_shift_n;
    logic [AW-1:0]     r_cur_addr,    w_cur_addr_n;
    logic [AW-1:0]     r_next_addr,   w_next_addr_n;
    logic [15:0]       r_frame_count, w_frame_count_n;
    logic              r_dout,        w_dout_n;
    logic              r_oe,          w_oe_n;
    logic              r_frame_done,  w_frame_done_n;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_async (ADC_SCLK),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    // CS_N idles high, so its synchronizer resets high to avoid a false select.
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_async (ADC_CS_N),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_din_sync <= '0;
        end else begin
            r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], ADC_DIN};
        end
    end

    assign w_din = r_din_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall) w_state_next = ACTIVE;
            ACTIVE:  if (w_cs_rise) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // cs_rise is checked first so a coincident SCLK edge is discarded.
    always_comb begin
        w_bit_cnt_n     = r_bit_cnt;
        w_shift_n       = r_shift;
        w_cur_addr_n    = r_cur_addr;
        w_next_addr_n   = r_next_addr;
        w_frame_count_n = r_frame_count;
        w_dout_n        = r_dout;
        w_frame_done_n  = 1'b0;
        w_oe_n          = (w_state_next == ACTIVE);
        case (r_state)
            IDLE: begin
                w_bit_cnt_n = '0;
                w_dout_n    = 1'b0;
                if (w_cs_fall) begin
                    w_shift_n = sample_in[r_cur_addr];
                end
            end
            ACTIVE: begin
                if (w_cs_rise) begin
                    w_bit_cnt_n = '0;
                    w_dout_n    = 1'b0;
                end else if (w_sclk_rise) begin
                    for (int k = 0; k < AW; k++) begin
                        if (r_bit_cnt == BW'(ADDR_FIRST_EDGE + k)) begin
                            w_next_addr_n[AW-1-k] = w_din;
                        end
                    end
                    if (r_bit_cnt == LAST_BIT) begin
                        w_cur_addr_n    = w_next_addr_n;
                        w_frame_done_n  = 1'b1;
                        w_frame_count_n = r_frame_count + 16'd1;
                    end
                end else if (w_sclk_fall) begin
                    w_bit_cnt_n = (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
                    if (w_bit_cnt_n == '0) begin
                        w_shift_n = sample_in[r_cur_addr];
                        w_dout_n  = 1'b0;
                    end else if (w_bit_cnt_n < BW'(LEAD_ZEROS)) begin
                        w_dout_n = 1'b0;
                    end else begin
                        w_dout_n  = r_shift[DATA_W-1];
                        w_shift_n = {r_shift[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: begin
                w_bit_cnt_n = '0;
                w_dout_n    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_cur_addr    <= '0;
            r_next_addr   <= '0;
            r_frame_count <= '0;
            r_dout        <= 1'b0;
            r_oe          <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_bit_cnt     <= w_bit_cnt_n;
            r_shift       <= w_shift_n;
            r_cur_addr    <= w_cur_addr_n;
            r_next_addr   <= w_next_addr_n;
            r_frame_count <= w_frame_count_n;
            r_dout        <= w_dout_n;
            r_oe          <= w_oe_n;
            r_frame_done  <= w_frame_done_n;
        end
    end

    assign ADC_DOUT    = r_dout;
    assign dout_oe     = r_oe;
    assign cur_addr    = r_cur_addr;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: drives SPI frames at a legal SCLK
// rate and checks shifted data, address commit, frame pulses and reset.
module tb_adc_spi_responder;
    import adc_spi_pkg::*;

    localparam int HALF = 6;

    logic        clock = 1'b0;
    logic        reset;
    logic        ADC_CS_N;
    logic        ADC_SCLK;
    logic        ADC_DIN;
    logic        ADC_DOUT;
    logic        dout_oe;
    sample_bus_t sample_in;
    logic [2:0]  cur_addr;
    logic        frame_done;
    logic [15:0] frame_count;
    resp_state_t dbg_state;

    int          n_checks   = 0;
    int          n_failures = 0;
    int          done_cycles = 0;
    logic [15:0] got_word;

    adc_spi_responder dut (
        .clock       (clock),
        .reset       (reset),
        .ADC_CS_N    (ADC_CS_N),
        .ADC_SCLK    (ADC_SCLK),
        .ADC_DIN     (ADC_DIN),
        .ADC_DOUT    (ADC_DOUT),
        .dout_oe     (dout_oe),
        .sample_in   (sample_in),
        .cur_addr    (cur_addr),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .dbg_state   (dbg_state)
    );

    always #10 clock = ~clock;

    always @(negedge clock) begin
        if (frame_done === 1'b1) done_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [15:0] ctrl(input logic [2:0] addr);
        return {2'b00, addr, 3'b000, 8'h00};
    endfunction

    // Shifts bits first..first+n-1 of din; DOUT is captured just before each rise.
    task automatic run_bits(input logic [15:0] din, input int first, input int n);
        ADC_DIN = din[15-first];
        wait_clk(2);
        for (int i = first; i < first + n; i++) begin
            got_word[15-i] = ADC_DOUT;
            ADC_SCLK = 1'b1;
            wait_clk(HALF);
            ADC_SCLK = 1'b0;
            wait_clk(3);
            if (i + 1 < 16) ADC_DIN = din[14-i];
            wait_clk(HALF - 3);
        end
    endtask

    initial begin
        reset     = 1'b0;
        ADC_CS_N  = 1'b1;
        ADC_SCLK  = 1'b0;
        ADC_DIN   = 1'b0;
        sample_in = '0;
        got_word  = '0;

        // Reset held with SCLK toggling
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            ADC_SCLK = ~ADC_SCLK;
        end
        check("rst_dout",  32'(ADC_DOUT),    32'h0);
        check("rst_oe",    32'(dout_oe),     32'h0);
        check("rst_addr",  32'(cur_addr),    32'h0);
        check("rst_count", 32'(frame_count), 32'h0);
        check("rst_done",  32'(done_cycles), 32'h0);
        check("rst_state", 32'(dbg_state),   32'(IDLE));
        reset    = 1'b1;
        ADC_SCLK = 1'b0;
        wait_clk(HALF);

        // Frame 1: channel 0 = ABC, select address 3
        sample_in[0] = 12'hABC;
        ADC_CS_N = 1'b0;
        wait_clk(2);
        check("oe_lat2", 32'(dout_oe), 32'h0);
        wait_clk(1);
        check("oe_lat3", 32'(dout_oe), 32'h1);
        wait_clk(HALF - 3);
        run_bits(ctrl(3'd3), 0, 16);
        ADC_CS_N = 1'b1;
        wait_clk(HALF);
        check("f1_word",  32'(got_word),    32'h0ABC);
        check("f1_addr",  32'(cur_addr),    32'h3);
        check("f1_done",  32'(done_cycles), 32'h1);
        check("f1_count", 32'(frame_count), 32'h1);
        check("f1_oe",    32'(dout_oe),     32'h0);
        check("f1_idle",  32'(ADC_DOUT),    32'h0);

        // Frame 2: channel 3 = 5A5, changed mid-frame to FFF
        sample_in[3] = 12'h5A5;
        ADC_CS_N = 1'b0;
        wait_clk(HALF);
        run_bits(ctrl(3'd0), 0, 8);
        sample_in[3] = 12'hFFF;
        run_bits(ctrl(3'd0), 8, 8);
        ADC_CS_N = 1'b1;
        wait_clk(HALF);
        check("f2_word",  32'(got_word),    32'h05A5);
        check("f2_addr",  32'(cur_addr),    32'h0);
        check("f2_done",  32'(done_cycles), 32'h2);
        check("f2_count", 32'(frame_count), 32'h2);

        // Continuous: 32 SCLK with CS_N held low
        sample_in[0] = 12'h123;
        sample_in[7] = 12'h3C1;
        ADC_CS_N = 1'b0;
        wait_clk(HALF);
        run_bits(ctrl(3'd7), 0, 16);
        check("c1_word", 32'(got_word), 32'h0123);
        check("c1_addr", 32'(cur_addr), 32'h7);
        run_bits(ctrl(3'd1), 0, 16);
        check("c2_word", 32'(got_word), 32'h03C1);
        ADC_CS_N = 1'b1;
        wait_clk(HALF);
        check("c_addr",  32'(cur_addr),    32'h1);
        check("c_done",  32'(done_cycles), 32'h4);
        check("c_count", 32'(frame_count), 32'h4);

        // Abort after 9 SCLK with address 5 shifted in
        ADC_CS_N = 1'b0;
        wait_clk(HALF);
        run_bits(ctrl(3'd5), 0, 9);
        ADC_CS_N = 1'b1;
        wait_clk(HALF);
        check("ab_addr",  32'(cur_addr),    32'h1);
        check("ab_done",  32'(done_cycles), 32'h4);
        check("ab_count", 32'(frame_count), 32'h4);
        check("ab_oe",    32'(dout_oe),     32'h0);
        check("ab_dout",  32'(ADC_DOUT),    32'h0);

        // Full frame after the abort
        sample_in[1] = 12'h9E7;
        ADC_CS_N = 1'b0;
        wait_clk(HALF);
        run_bits(ctrl(3'd2), 0, 16);
        ADC_CS_N = 1'b1;
        wait_clk(HALF);
        check("pa_word",  32'(got_word),    32'h09E7);
        check("pa_addr",  32'(cur_addr),    32'h2);
        check("pa_count", 32'(frame_count), 32'h5);

        // Reset asserted at SCLK 10 of a frame
        sample_in[2] = 12'hFFF;
        ADC_CS_N = 1'b0;
        wait_clk(HALF);
        run_bits(ctrl(3'd6), 0, 10);
        check("pre_rst_dout", 32'(ADC_DOUT), 32'h1);
        reset = 1'b0;
        #1;
        check("mr_dout",  32'(ADC_DOUT),    32'h0);
        check("mr_oe",    32'(dout_oe),     32'h0);
        check("mr_addr",  32'(cur_addr),    32'h0);
        check("mr_count", 32'(frame_count), 32'h0);
        check("mr_state", 32'(dbg_state),   32'(IDLE));
        wait_clk(2);
        ADC_CS_N = 1'b1;
        wait_clk(2);
        reset = 1'b1;
        wait_clk(HALF);
        check("mr_done", 32'(done_cycles), 32'h5);

        // Preload the counter to FFFF, then one frame wraps it to 0
        force dut.r_frame_count = 16'hFFFF;
        wait_clk(1);
        release dut.r_frame_count;
        wait_clk(1);
        check("pre_wrap", 32'(frame_count), 32'hFFFF);
        sample_in[0] = 12'h777;
        ADC_CS_N = 1'b0;
        wait_clk(HALF);
        run_bits(ctrl(3'd4), 0, 16);
        ADC_CS_N = 1'b1;
        wait_clk(HALF);
        check("w_word",  32'(got_word),    32'h0777);
        check("w_count", 32'(frame_count), 32'h0);
        check("w_addr",  32'(cur_addr),    32'h4);
        check("w_done",  32'(done_cycles), 32'h6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
